// File: rtl/pe_evolve_pkg.sv
// pe_evolve_pkg: shared types and constants for the node-evolution PE.
// Nucleotide codes, FSM states, Galois LFSR taps, packet field offsets.
package pe_evolve_pkg;

  localparam logic [1:0] NT_A = 2'b00;
  localparam logic [1:0] NT_C = 2'b01;
  localparam logic [1:0] NT_G = 2'b10;
  localparam logic [1:0] NT_T = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GEN,
    S_OUT
  } state_e;

  // Right-shifting Galois masks of maximal-length polynomials.
  function automatic logic [31:0] lfsr_taps(int w);
    case (w)
      8:       return 32'h0000_00B8;
      10:      return 32'h0000_0240;
      12:      return 32'h0000_0E08;
      16:      return 32'h0000_B400;
      20:      return 32'h0009_0000;
      24:      return 32'h00E1_0000;
      32:      return 32'hA300_0000;
      default: return 32'h0000_B400;
    endcase
  endfunction

  // Packet = {seq, child1[2:0], child2[2:0], P}
  function automatic int P_LSB();
    return 0;
  endfunction

  function automatic int CH2_LSB(int prob_w);
    return 16 * prob_w;
  endfunction

  function automatic int CH1_LSB(int prob_w);
    return 16 * prob_w + 3;
  endfunction

  function automatic int SEQ_LSB(int prob_w);
    return 16 * prob_w + 6;
  endfunction

  function automatic int PKT_W(int n_sites, int prob_w);
    return 2 * n_sites + 6 + 16 * prob_w;
  endfunction

endpackage

// File: rtl/pe_evolve_core_sampler.sv
// pe_nt_sampler: one lane - Galois LFSR plus 4-way cumulative draw.
// Ports: clk, reset, load_i (seed mix), adv_i (step), seed_id_i, row_i {pA,pC,pG}, nt_o.
module pe_nt_sampler
  import pe_evolve_pkg::*;
#(
  parameter int PROB_W = 10,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] INIT = '1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  adv_i,
  input  logic [7:0]            seed_id_i,
  input  logic [3*PROB_W-1:0]   row_i,
  output logic [1:0]            nt_o
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));
  localparam int CW = PROB_W + 2;

  logic [LFSR_W-1:0] lfsr_q, lfsr_d, mix, mixed;
  logic [CW-1:0] r, c0, c1, c2;

  always_comb begin
    for (int i = 0; i < LFSR_W; i++) begin
      mix[i] = seed_id_i[3'(i % 8)];
    end
  end

  assign mixed = lfsr_q ^ mix;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (mixed == '0) ? LFSR_W'(1) : mixed;
    end else if (adv_i) begin
      lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]}
             ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= INIT;
    else       lfsr_q <= lfsr_d;
  end

  assign r  = CW'(lfsr_q[PROB_W-1:0]);
  assign c0 = CW'(row_i[3*PROB_W-1 -: PROB_W]);
  assign c1 = c0 + CW'(row_i[2*PROB_W-1 -: PROB_W]);
  assign c2 = c1 + CW'(row_i[PROB_W-1:0]);

  // Ordered compare: oversubscribed rows still resolve.
  always_comb begin
    if (r < c0)      nt_o = NT_A;
    else if (r < c1) nt_o = NT_C;
    else if (r < c2) nt_o = NT_G;
    else             nt_o = NT_T;
  end

endmodule

// File: rtl/pe_evolve_core.sv
// pe_evolve_core: evolves a node packet with N_LANES samplers, fans out to both children.
// Ports: clk, reset, seed_id, in_*, out_*, out1/out2, leaf, result, busy; perf_* under PE_EVOLVE_PERF_CNT_EN.
module pe_evolve_core
  import pe_evolve_pkg::*;
#(
  parameter int N_SITES = 16,
  parameter int N_LANES = 4,
  parameter int PROB_W  = 10,
  parameter int LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [7:0]                         seed_id,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [PKT_W(N_SITES,PROB_W)-1:0]   in_pkt,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [PKT_W(N_SITES,PROB_W)-1:0]   out1,
  output logic [PKT_W(N_SITES,PROB_W)-1:0]   out2,
  output logic                               leaf,
  output logic [2*N_SITES-1:0]               result,
  output logic                               busy
`ifdef PE_EVOLVE_PERF_CNT_EN
  ,
  output logic [31:0]                        perf_pkts,
  output logic [31:0]                        perf_leaf
`endif
);

  localparam int PW    = PKT_W(N_SITES, PROB_W);
  localparam int SW    = 2 * N_SITES;
  localparam int PB    = 16 * PROB_W;
  localparam int BEATS = N_SITES / N_LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e            state_q;
  logic [SW-1:0]     seq_q, seq_nx;
  logic [5:0]        ch_q;
  logic [PB-1:0]     p_q;
  logic [BW-1:0]     beat_q;
  logic [PW-1:0]     out_q;
  logic [SW-1:0]     result_q;
  logic              leaf_q, out_valid_q, in_ready_q, busy_q;

  logic [SW-1:0]     seq_in;
  logic [2:0]        ch1_in, ch2_in;
  logic [PB-1:0]     p_in;
  logic              bypass, leaf_in, accept, last;

  logic [1:0]          nt  [N_LANES];
  logic [3*PROB_W-1:0] row [N_LANES];

  assign seq_in  = in_pkt[SEQ_LSB(PROB_W) +: SW];
  assign ch1_in  = in_pkt[CH1_LSB(PROB_W) +: 3];
  assign ch2_in  = in_pkt[CH2_LSB(PROB_W) +: 3];
  assign p_in    = in_pkt[P_LSB() +: PB];
  assign bypass  = (seq_in == '0) || (p_in == '0);
  assign leaf_in = (ch1_in == 3'd0) && (ch2_in == 3'd0);
  assign accept  = (state_q == S_IDLE) && in_valid;
  assign last    = beat_q == BW'(BEATS - 1);

  // Rows come from the old sites; each site is written exactly once.
  always_comb begin
    seq_nx = seq_q;
    for (int k = 0; k < N_LANES; k++) begin
      int s;
      int v;
      s = int'(beat_q) * N_LANES + k;
      v = int'(seq_q[2*s +: 2]);
      row[k] = p_q[4*PROB_W*(3-v) + PROB_W +: 3*PROB_W];
      seq_nx[2*s +: 2] = nt[k];
    end
  end

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    pe_nt_sampler #(
      .PROB_W (PROB_W),
      .LFSR_W (LFSR_W),
      .INIT   (SEED ^ LFSR_W'(k + 1))
    ) u_smp (
      .clk       (clk),
      .reset     (reset),
      .load_i    (accept),
      .adv_i     (state_q == S_GEN),
      .seed_id_i (seed_id),
      .row_i     (row[k]),
      .nt_o      (nt[k])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      seq_q       <= '0;
      ch_q        <= '0;
      p_q         <= '0;
      beat_q      <= '0;
      out_q       <= '0;
      result_q    <= '0;
      leaf_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            seq_q      <= seq_in;
            ch_q       <= {ch1_in, ch2_in};
            p_q        <= p_in;
            leaf_q     <= leaf_in;
            beat_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (bypass) begin
              state_q     <= S_OUT;
              out_q       <= in_pkt;
              out_valid_q <= 1'b1;
              result_q    <= leaf_in ? seq_in : '0;
            end else begin
              state_q <= S_GEN;
            end
          end
        end
        S_GEN: begin
          seq_q  <= seq_nx;
          beat_q <= beat_q + BW'(1);
          if (last) begin
            state_q     <= S_OUT;
            out_q       <= {seq_nx, ch_q, {PB{1'b0}}};
            out_valid_q <= 1'b1;
            result_q    <= leaf_q ? seq_nx : '0;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out1      = out_q;
  assign out2      = out_q;
  assign leaf      = leaf_q;
  assign result    = result_q;
  assign busy      = busy_q;

`ifdef PE_EVOLVE_PERF_CNT_EN
  logic [31:0] pkts_q, leafc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkts_q  <= '0;
      leafc_q <= '0;
    end else if (out_valid_q && out_ready) begin
      pkts_q <= pkts_q + 32'd1;
      if (leaf_q) leafc_q <= leafc_q + 32'd1;
    end
  end

  assign perf_pkts = pkts_q;
  assign perf_leaf = leafc_q;
`endif

endmodule

// File: tb/tb_pe_evolve_core.sv
// tb_pe_evolve_core: directed vectors plus a lane-LFSR reference model.
// Covers reset, deterministic rows, leaf, bypass, backpressure, async reset, statistics.
module tb_pe_evolve_core;

  localparam int NS  = 16;
  localparam int NL  = 4;
  localparam int PWB = 10;
  localparam int PKW = 2*NS + 6 + 16*PWB;

  logic            clk = 1'b0;
  logic            reset, in_valid, in_ready;
  logic            out_valid, out_ready, leaf, busy;
  logic [7:0]      seed_id;
  logic [PKW-1:0]  in_pkt, out1, out2;
  logic [2*NS-1:0] result;
`ifdef PE_EVOLVE_PERF_CNT_EN
  logic [31:0]     perf_pkts, perf_leaf;
`endif

  always #5 clk = ~clk;

  pe_evolve_core dut (
    .clk       (clk),
    .reset     (reset),
    .seed_id   (seed_id),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pkt    (in_pkt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out1      (out1),
    .out2      (out2),
    .leaf      (leaf),
    .result    (result),
    .busy      (busy)
`ifdef PE_EVOLVE_PERF_CNT_EN
    ,
    .perf_pkts (perf_pkts),
    .perf_leaf (perf_leaf)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int hs_pkts = 0;
  int hs_leaf = 0;

  task automatic check(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] lf [NL];

  task automatic m_reset();
    for (int k = 0; k < NL; k++) lf[k] = 16'hACE1 ^ 16'(k + 1);
  endtask

  task automatic m_accept(input logic [7:0] sid);
    logic [15:0] x;
    for (int k = 0; k < NL; k++) begin
      x = lf[k] ^ {sid, sid};
      lf[k] = (x == 16'h0) ? 16'h1 : x;
    end
  endtask

  function automatic logic [15:0] m_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0);
  endfunction

  function automatic logic [1:0] m_draw(input logic [29:0] abc,
                                        input logic [9:0] r);
    logic [11:0] c0, c1, c2, rr;
    rr = {2'b0, r};
    c0 = {2'b0, abc[29:20]};
    c1 = c0 + {2'b0, abc[19:10]};
    c2 = c1 + {2'b0, abc[9:0]};
    if (rr < c0) return 2'd0;
    if (rr < c1) return 2'd1;
    if (rr < c2) return 2'd2;
    return 2'd3;
  endfunction

  task automatic m_gen(input logic [31:0] seq, input logic [159:0] p,
                       output logic [31:0] nseq);
    logic [39:0] rw;
    nseq = seq;
    for (int b = 0; b < NS/NL; b++) begin
      for (int k = 0; k < NL; k++) begin
        int s;
        int v;
        s = b*NL + k;
        v = int'(seq[2*s +: 2]);
        rw = p[40*(3-v) +: 40];
        nseq[2*s +: 2] = m_draw(rw[39:10], lf[k][9:0]);
      end
      for (int k = 0; k < NL; k++) lf[k] = m_step(lf[k]);
    end
  endtask

  function automatic logic [39:0] mkrow(int a, int c, int g, int t);
    return {10'(a), 10'(c), 10'(g), 10'(t)};
  endfunction

  function automatic logic [159:0] mkp(input logic [39:0] r);
    return {r, r, r, r};
  endfunction

  function automatic logic [PKW-1:0] mkpkt(input logic [31:0] s,
                                           input logic [2:0] c1,
                                           input logic [2:0] c2,
                                           input logic [159:0] p);
    return {s, c1, c2, p};
  endfunction

  task automatic send(input logic [PKW-1:0] p, input logic [7:0] sid);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("accept_timeout", 1'b0, 1'b1);
    seed_id  = sid;
    in_pkt   = p;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    m_accept(sid);
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_out(input bit lfx);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    hs_pkts++;
    if (lfx) hs_leaf++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [159:0]   p;
    logic [31:0]    sq, ex;
    logic [PKW-1:0] pk;
    int             lat;
    int             cnt [4];

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    seed_id = 8'h00; in_pkt = '0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_leaf", leaf, 1'b0);
    check("rst_out1", out1, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b1);

    // Deterministic rows: everything goes to A.
    p  = mkp(mkrow(1023, 0, 0, 0));
    sq = 32'h5555_5555;
    send(mkpkt(sq, 3'd1, 3'd2, p), 8'h5A);
    m_gen(sq, p, ex);
    wait_out(lat);
    check("det_lat", lat, 5);
    check("det_seq_model", out1[PKW-1 -: 32], ex);
    check("det_pfield", out1[159:0], 0);
    check("det_children", out1[165:160], {3'd1, 3'd2});
    check("det_out2", out2, mkpkt(ex, 3'd1, 3'd2, '0));
    check("det_leaf", leaf, 1'b0);
    check("det_result", result, 0);
    check("det_in_ready", in_ready, 1'b0);
    check("det_busy", busy, 1'b1);
    finish_out(1'b0);
    check("det_ret_valid", out_valid, 1'b0);
    check("det_ret_ready", in_ready, 1'b1);
    check("det_ret_busy", busy, 1'b0);

    // Leaf with all-T rows.
    p = mkp(mkrow(0, 0, 0, 1023));
    send(mkpkt(32'h0000_0001, 3'd0, 3'd0, p), 8'h11);
    m_gen(32'h0000_0001, p, ex);
    wait_out(lat);
    check("leaf_lat", lat, 5);
    check("leaf_result", result, 32'hFFFF_FFFF);
    check("leaf_flag", leaf, 1'b1);
    check("leaf_out1", out1, mkpkt(32'hFFFF_FFFF, 3'd0, 3'd0, '0));
    check("leaf_out2", out2, mkpkt(32'hFFFF_FFFF, 3'd0, 3'd0, '0));
    finish_out(1'b1);

    // Bypass on P == 0.
    pk = mkpkt(32'h1234_5678, 3'd3, 3'd5, '0);
    send(pk, 8'h22);
    wait_out(lat);
    check("byp_lat", lat, 1);
    check("byp_out1", out1, pk);
    check("byp_out2", out2, pk);
    check("byp_leaf", leaf, 1'b0);
    check("byp_result", result, 0);
    finish_out(1'b0);

    // Bypass on seq == 0, leaf: P kept, result is the zero seq.
    pk = mkpkt(32'h0, 3'd0, 3'd0, mkp(mkrow(256, 256, 256, 255)));
    send(pk, 8'h33);
    wait_out(lat);
    check("byp0_lat", lat, 1);
    check("byp0_out1", out1, pk);
    check("byp0_leaf", leaf, 1'b1);
    check("byp0_result", result, 0);
    finish_out(1'b1);

    // Backpressure: hold in OUT for 10 cycles.
    p  = mkp(mkrow(100, 200, 300, 423));
    sq = 32'hE4E4_1B1B;
    send(mkpkt(sq, 3'd4, 3'd6, p), 8'h77);
    m_gen(sq, p, ex);
    wait_out(lat);
    check("bp_lat", lat, 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out1", out1, mkpkt(ex, 3'd4, 3'd6, '0));
      check("bp_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
    end
    finish_out(1'b0);
    check("bp_ret_ready", in_ready, 1'b1);
    check("bp_ret_busy", busy, 1'b0);

    // Async reset in the middle of GEN.
    send(mkpkt(32'hDEAD_BEEF, 3'd0, 3'd0, mkp(mkrow(0, 0, 0, 1023))),
         8'h44);
    @(negedge clk);
    @(negedge clk);
    check("mid_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ready", in_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_result", result, 0);
    check("mid_rst_out1", out1, 0);
    check("mid_rst_leaf", leaf, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    hs_pkts = 0;
    hs_leaf = 0;

    // First packet after reset checks the lane seeds.
    p  = mkp(mkrow(256, 256, 256, 255));
    sq = 32'hE4E4_E4E4;
    send(mkpkt(sq, 3'd0, 3'd0, p), 8'h3C);
    m_gen(sq, p, ex);
    wait_out(lat);
    check("seed_lat", lat, 5);
    check("seed_seq", out1[PKW-1 -: 32], ex);
    check("seed_result", result, ex);
    finish_out(1'b1);

    // Statistics over 4096 uniform-row packets.
    for (int v = 0; v < 4; v++) cnt[v] = 0;
    for (int n = 0; n < 4096; n++) begin
      send(mkpkt(sq, 3'd1, 3'd1, p), 8'h3C);
      m_gen(sq, p, ex);
      wait_out(lat);
      if (!out_valid) begin
        check("st_timeout", 1'b0, 1'b1);
        break;
      end
      check("st_seq", out1[PKW-1 -: 32], ex);
      for (int s = 0; s < NS; s++) begin
        int v;
        v = int'(out1[PKW-32 + 2*s +: 2]);
        cnt[v]++;
      end
      finish_out(1'b0);
    end
    for (int v = 0; v < 4; v++) begin
      check($sformatf("st_freq_nt%0d", v),
            (cnt[v] >= 15073 && cnt[v] <= 17695), 1'b1);
    end

`ifdef PE_EVOLVE_PERF_CNT_EN
    @(negedge clk);
    check("perf_pkts", perf_pkts, hs_pkts);
    check("perf_leaf", perf_leaf, hs_leaf);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
